// File: rtl/mdu_pkg.sv
// Shared op/state types and op-decoding helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_mul(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_acc(input mdu_op_e op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_sub(input mdu_op_e op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// Combinational restoring-division slice: DIV_BITS quotient bits per call on
// unsigned magnitudes. The dividend shifts out of i_quo as quotient bits shift in.
module mdu_div_step #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvs,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);
    always_comb begin
        logic [XLEN:0]   v_sh;
        logic [XLEN-1:0] v_rem;
        logic [XLEN-1:0] v_quo;
        v_sh  = '0;
        v_rem = i_rem;
        v_quo = i_quo;
        for (int k = 0; k < DIV_BITS; k++) begin
            v_sh  = {v_rem, v_quo[XLEN-1]};
            v_quo = {v_quo[XLEN-2:0], 1'b0};
            if (v_sh >= {1'b0, i_dvs}) begin
                v_sh     = v_sh - {1'b0, i_dvs};
                v_quo[0] = 1'b1;
            end
            v_rem = v_sh[XLEN-1:0];
        end
        o_rem = v_rem;
        o_quo = v_quo;
    end
endmodule

// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit beside the EX-stage ALU: pipelined multiplier, iterative
// restoring divider, MADD/MSUB accumulate, flush-abort and an accept/busy handshake.
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 3,
    parameter int DIV_BITS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            op_valid,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            hilo_rd,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy,
    output logic            stall_o,
    output logic            done
);
    localparam int PW        = 2 * XLEN;
    localparam int DIV_ITERS = XLEN / DIV_BITS;
    localparam int CNT_W     = $clog2(DIV_ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS);

    mdu_state_e      r_state, w_state_nxt;
    mdu_op_e         w_op;
    logic            w_accept, w_start_mul, w_start_div;
    logic            w_mul_done, w_div_done, w_complete;
    logic [XLEN-1:0] r_hi, r_lo;
    logic            r_done;

    assign w_op        = mdu_op_e'(op);
    assign busy        = (r_state != IDLE);
    assign w_accept    = op_valid & ~busy & ~stall_i & ~flush_i;
    assign w_start_mul = w_accept & is_mul(w_op);
    assign w_start_div = w_accept & is_div(w_op);
    assign stall_o     = busy & (op_valid | hilo_rd);
    assign hi_o        = r_hi;
    assign lo_o        = r_lo;
    assign done        = r_done;

    // Multiplier: one XLEN+1 signed product, then a MUL_STAGES-deep register pipe.
    logic signed [XLEN:0] w_a_ext, w_b_ext;
    logic [PW-1:0]        w_prod;
    logic [PW-1:0]        r_prod_p [MUL_STAGES];
    logic [MUL_STAGES-1:0] r_vld_p;
    logic                 r_acc, r_sub;

    assign w_a_ext = $signed({is_signed(w_op) & src_a[XLEN-1], src_a});
    assign w_b_ext = $signed({is_signed(w_op) & src_b[XLEN-1], src_b});
    assign w_prod  = PW'(w_a_ext) * PW'(w_b_ext);

    always_ff @(posedge clk) begin
        if (w_start_mul) begin
            r_prod_p[0] <= w_prod;
            r_acc       <= is_acc(w_op);
            r_sub       <= is_sub(w_op);
        end
        for (int i = 1; i < MUL_STAGES; i++) r_prod_p[i] <= r_prod_p[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_start_mul;
            for (int i = 1; i < MUL_STAGES; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    // Divider: magnitudes captured at accept, DIV_BITS per cycle, signs fixed on the last cycle.
    logic [XLEN-1:0]  w_abs_a, w_abs_b, w_rem_nxt, w_quo_nxt;
    logic             w_neg_a, w_neg_b;
    logic [XLEN-1:0]  r_rem, r_quo, r_dvs;
    logic             r_neg_q, r_neg_r, r_dz;
    logic [CNT_W-1:0] r_cnt;
    logic             w_div_iter;

    assign w_neg_a    = is_signed(w_op) & src_a[XLEN-1];
    assign w_neg_b    = is_signed(w_op) & src_b[XLEN-1];
    assign w_abs_a    = w_neg_a ? -src_a : src_a;
    assign w_abs_b    = w_neg_b ? -src_b : src_b;
    assign w_div_iter = (r_state == DIV) && (r_cnt != CNT_LAST);

    mdu_div_step #(
        .XLEN     (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (w_start_div) begin
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_dz    <= (src_b == '0);
        end else if (w_div_iter) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_div) r_cnt <= '0;
        else if (w_div_iter)    r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_mul_done = (r_state == MUL) & r_vld_p[MUL_STAGES-1];
    assign w_div_done = (r_state == DIV) & (r_cnt == CNT_LAST);
    assign w_complete = (w_mul_done | w_div_done) & ~flush_i;

    // Result selection; accumulate reads HI/LO as they stand at the completion edge.
    logic [PW-1:0]   w_hilo, w_mul_res, w_div_res;
    logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_lo_div;

    assign w_hilo    = {r_hi, r_lo};
    assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;
    assign w_lo_div  = r_dz ? '1 : w_quo_fix;
    assign w_div_res = {w_rem_fix, w_lo_div};

    always_comb begin
        w_mul_res = r_prod_p[MUL_STAGES-1];
        if (r_acc) begin
            w_mul_res = r_sub ? (w_hilo - r_prod_p[MUL_STAGES-1])
                              : (w_hilo + r_prod_p[MUL_STAGES-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept && w_op == OP_MTHI) begin
            r_hi <= src_a;
        end else if (w_accept && w_op == OP_MTLO) begin
            r_lo <= src_a;
        end else if (w_complete) begin
            {r_hi, r_lo} <= w_mul_done ? w_mul_res : w_div_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_complete;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_mul)      w_state_nxt = MUL;
                else if (w_start_div) w_state_nxt = DIV;
            end
            MUL:     if (flush_i || w_mul_done) w_state_nxt = IDLE;
            DIV:     if (flush_i || w_div_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: three instances (DIV_BITS 1/2/4) share stimulus; a transaction-level
// model predicts HI/LO/busy/done/stall_o every cycle, plus literal checks on key cases.
module tb_hilo_mdu;
    import mdu_pkg::*;

    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 3;
    localparam int NDUT       = 3;

    logic        clk, rst, stall_i, flush_i, op_valid, hilo_rd;
    logic [3:0]  op;
    logic [31:0] src_a, src_b;
    logic [31:0] hi_o [NDUT];
    logic [31:0] lo_o [NDUT];
    logic        busy [NDUT];
    logic        stall_o [NDUT];
    logic        done [NDUT];

    hilo_mdu #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .DIV_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .op_valid(op_valid),
        .op(op), .src_a(src_a), .src_b(src_b), .hilo_rd(hilo_rd),
        .hi_o(hi_o[0]), .lo_o(lo_o[0]), .busy(busy[0]), .stall_o(stall_o[0]), .done(done[0]));
    hilo_mdu #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .DIV_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .op_valid(op_valid),
        .op(op), .src_a(src_a), .src_b(src_b), .hilo_rd(hilo_rd),
        .hi_o(hi_o[1]), .lo_o(lo_o[1]), .busy(busy[1]), .stall_o(stall_o[1]), .done(done[1]));
    hilo_mdu #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .DIV_BITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .op_valid(op_valid),
        .op(op), .src_a(src_a), .src_b(src_b), .hilo_rd(hilo_rd),
        .hi_o(hi_o[2]), .lo_o(lo_o[2]), .busy(busy[2]), .stall_o(stall_o[2]), .done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    // Reference model state, one slot per instance.
    logic [31:0] m_hi [NDUT];
    logic [31:0] m_lo [NDUT];
    logic [3:0]  m_op [NDUT];
    logic [31:0] m_a  [NDUT];
    logic [31:0] m_b  [NDUT];
    bit          m_busy [NDUT];
    bit          m_done [NDUT];
    int          m_cnt  [NDUT];

    function automatic int div_lat(input int i);
        return XLEN / (1 << i) + 1;
    endfunction

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        return 64'(sa * sb);
    endfunction

    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint x, y, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] opc, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hl);
        case (mdu_op_e'(opc))
            OP_MULT:  return mul64(a, b, 1'b1);
            OP_MULTU: return mul64(a, b, 1'b0);
            OP_MADD:  return hl + mul64(a, b, 1'b1);
            OP_MADDU: return hl + mul64(a, b, 1'b0);
            OP_MSUB:  return hl - mul64(a, b, 1'b1);
            OP_MSUBU: return hl - mul64(a, b, 1'b0);
            OP_DIV:   return div64(a, b, 1'b1);
            OP_DIVU:  return div64(a, b, 1'b0);
            default:  return hl;
        endcase
    endfunction

    task automatic model_step();
        mdu_op_e o;
        o = mdu_op_e'(op);
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                m_hi[i] = '0; m_lo[i] = '0; m_busy[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_busy[i]) begin
                    if (flush_i) begin
                        m_busy[i] = 0;
                    end else begin
                        m_cnt[i]--;
                        if (m_cnt[i] == 0) begin
                            {m_hi[i], m_lo[i]} = ref_result(m_op[i], m_a[i], m_b[i], {m_hi[i], m_lo[i]});
                            m_busy[i] = 0;
                            m_done[i] = 1;
                        end
                    end
                end else if (op_valid && !stall_i && !flush_i) begin
                    if (o == OP_MTHI) m_hi[i] = src_a;
                    else if (o == OP_MTLO) m_lo[i] = src_a;
                    else if (o inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
                                       OP_DIV, OP_DIVU}) begin
                        m_busy[i] = 1;
                        m_op[i] = op; m_a[i] = src_a; m_b[i] = src_b;
                        m_cnt[i] = (o inside {OP_DIV, OP_DIVU}) ? div_lat(i) : MUL_STAGES;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("hi[%0d]", i), hi_o[i], m_hi[i]);
            check($sformatf("lo[%0d]", i), lo_o[i], m_lo[i]);
            check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_busy[i]));
            check($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
            check($sformatf("stall_o[%0d]", i), 32'(stall_o[i]),
                  32'(m_busy[i] & (op_valid | hilo_rd)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (cmp_en) compare_all();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", n);
        end
    endtask

    // Issues one op, returns cycles from the accept edge until dut1 shows done, then drains all.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        op_valid = 1'b0;
        lat = 0;
        while (!done[0] && lat < 100) begin
            tick();
            lat++;
        end
        wait_idle();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        logic [31:0] sv_hi, sv_lo;
        rst = 1'b1; stall_i = 0; flush_i = 0; op_valid = 0; hilo_rd = 0;
        op = '0; src_a = '0; src_b = '0;
        tick();
        cmp_en = 1;
        tick();
        rst = 1'b0;
        check("reset hi", hi_o[0], 32'h0);
        check("reset lo", lo_o[0], 32'h0);
        check("reset busy", 32'(busy[0]), 32'h0);
        tick();

        op_valid = 1; op = OP_MTHI; src_a = 32'h1234; tick();
        op = OP_MTLO; src_a = 32'h5678; tick();
        op_valid = 0; tick();
        check("mthi", hi_o[0], 32'h1234);
        check("mtlo", lo_o[0], 32'h5678);

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, lat);
        check("mult lat", 32'(lat), 32'd3);
        check("mult hi", hi_o[0], 32'hFFFF_FFFF);
        check("mult lo", lo_o[0], 32'hFFFF_FFFE);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, lat);
        check("multu hi", hi_o[0], 32'h1);
        check("multu lo", lo_o[0], 32'hFFFF_FFFE);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, lat);
        check("div lat", 32'(lat), 32'd33);
        check("div lo", lo_o[0], 32'hFFFF_FFFD);
        check("div hi", hi_o[0], 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'h7, 32'h0, lat);
        check("divu0 lat", 32'(lat), 32'd33);
        check("divu0 lo", lo_o[0], 32'hFFFF_FFFF);
        check("divu0 hi", hi_o[0], 32'h7);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("divmin lo", lo_o[0], 32'h8000_0000);
        check("divmin hi", hi_o[0], 32'h0);

        op_valid = 1; op = OP_MTHI; src_a = 32'h0; tick();
        op = OP_MTLO; src_a = 32'd10; tick();
        op_valid = 0;
        run_op(OP_MADD, 32'd3, 32'd4, lat);
        check("madd hi", hi_o[0], 32'h0);
        check("madd lo", lo_o[0], 32'd22);
        run_op(OP_MSUBU, 32'd1, 32'd23, lat);
        check("msubu hi", hi_o[0], 32'hFFFF_FFFF);
        check("msubu lo", lo_o[0], 32'hFFFF_FFFF);

        // Flush a divide partway through.
        sv_hi = hi_o[0]; sv_lo = lo_o[0];
        op_valid = 1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7; tick();
        op_valid = 0;
        for (int k = 0; k < 9; k++) tick();
        flush_i = 1; tick();
        flush_i = 0;
        check("flush busy", 32'(busy[0]), 32'h0);
        check("flush hi", hi_o[0], sv_hi);
        check("flush lo", lo_o[0], sv_lo);
        tick();
        check("flush done", 32'(done[0]), 32'h0);
        wait_idle();
        run_op(OP_MULT, 32'd5, 32'd6, lat);
        check("post-flush lat", 32'(lat), 32'd3);
        check("post-flush lo", lo_o[0], 32'd30);
        check("post-flush hi", hi_o[0], 32'h0);

        // EX holds MFHI plus a queued MTLO while a divide runs.
        op_valid = 1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; tick();
        op = OP_MTLO; src_a = 32'hABCD; hilo_rd = 1;
        tick(); tick(); tick();
        check("stall_o held", 32'(stall_o[0]), 32'h1);
        lat = 0;
        while (!done[0] && lat < 100) begin
            tick();
            lat++;
        end
        check("stall_o released", 32'(stall_o[0]), 32'h0);
        check("divu lo", lo_o[0], 32'd333);
        check("divu hi", hi_o[0], 32'd1);
        tick();
        check("queued mtlo", lo_o[0], 32'hABCD);
        op_valid = 0; hilo_rd = 0;
        wait_idle();

        // Reset in the middle of a divide.
        op_valid = 1; op = OP_DIV; src_a = 32'd55; src_b = 32'd5; tick();
        op_valid = 0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1; tick();
        rst = 0;
        check("rst-mid hi", hi_o[0], 32'h0);
        check("rst-mid lo", lo_o[0], 32'h0);
        check("rst-mid busy", 32'(busy[0]), 32'h0);
        tick();

        // Random sweep across all three divider widths.
        for (int c = 0; c < 4000; c++) begin
            op_valid = ($urandom_range(0, 99) < 35);
            op       = 4'($urandom_range(0, 9));
            src_a    = pick();
            src_b    = pick();
            stall_i  = ($urandom_range(0, 99) < 8);
            flush_i  = ($urandom_range(0, 99) < 1);
            hilo_rd  = ($urandom_range(0, 99) < 20);
            tick();
        end
        op_valid = 0; stall_i = 0; flush_i = 0; hilo_rd = 0;
        wait_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
